// File: rtl/blink_sbox_layer_serial.sv
// Blink-128 nibble substitution layer: 32 nibbles pushed through NSBOX S-boxes per cycle over 32/NSBOX passes.
// Latency 32/NSBOX cycles from accept to out_valid; HOLD stalls on ~out_ready and accepts back-to-back on handshake.
module blink_sbox_layer_serial #(
    parameter int          NSBOX = 8,
    parameter logic [63:0] SBOX  = 64'h21748FE3DA09B65C
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if ((NSBOX < 1) || (NSBOX > 32) || ((32 % NSBOX) != 0)) begin : g_bad_nsbox
        $error("blink_sbox_layer_serial: NSBOX must divide 32");
    end

    localparam int NPASS = 32 / NSBOX;
    localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int W     = 4 * NSBOX;
    localparam logic [CW-1:0] LAST = CW'(NPASS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [127:0]  st_reg;
    logic [7:0]    base;
    logic [W-1:0]  win_in;
    logic [W-1:0]  win_out;

    function automatic logic [3:0] sbox_f(input logic [3:0] x);
        sbox_f = SBOX[{x, 2'b00} +: 4];
    endfunction

    // Window of nibbles handled on the current pass; base never exceeds 124.
    assign base   = 8'(cnt) * 8'(W);
    assign win_in = st_reg[base +: W];

    always_comb begin
        win_out = '0;
        for (int j = 0; j < NSBOX; j++) begin
            win_out[4*j +: 4] = sbox_f(win_in[4*j +: 4]);
        end
    end

    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign out_data = st_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            st_reg    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st_reg <= in_data;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    st_reg[base +: W] <= win_out;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // Output handshake may coincide with accepting the next state.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            st_reg <= in_data;
                            cnt    <= '0;
                            state  <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_sbox_layer_serial.sv
// Bench for blink_sbox_layer_serial: three instances (NSBOX 8, 32, 1) checked against a scoreboard
// of reference substitutions with accept-to-valid latency, stall stability and handshake checks.
module tb_blink_sbox_layer_serial;

    localparam logic [3:0] STAB [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef struct {
        logic [127:0] dat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n     [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];

    exp_t exp_q [3][$];
    logic [2:0] prev_ov = '0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        blink_sbox_layer_serial #(
            .NSBOX((g == 0) ? 8 : ((g == 1) ? 32 : 1))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g])
        );
    end

    function automatic int npass(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] x);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[4*k +: 4] = STAB[x[4*k +: 4]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mon_one(input int d);
        exp_t e;
        if (!rst_n[d]) begin
            exp_q[d].delete();
            prev_ov[d] = 1'b0;
            chk($sformatf("u%0d_rst_vld", d), 128'(out_valid[d]), 128'(0));
            chk($sformatf("u%0d_rst_dat", d), out_data[d], 128'(0));
            chk($sformatf("u%0d_rst_rdy", d), 128'(in_ready[d]), 128'(1));
            return;
        end
        if (out_valid[d]) begin
            if (exp_q[d].size() == 0) begin
                chk($sformatf("u%0d_spurious_vld", d), 128'(out_valid[d]), 128'(0));
            end else begin
                e = exp_q[d][0];
                chk($sformatf("u%0d_data", d), out_data[d], e.dat);
                if (!prev_ov[d])
                    chk($sformatf("u%0d_latency", d), 128'(cyc - e.acc), 128'(npass(d)));
                chk($sformatf("u%0d_hold_rdy", d), 128'(in_ready[d]), 128'(out_ready[d]));
                if (out_ready[d]) void'(exp_q[d].pop_front());
            end
        end else if (exp_q[d].size() > 0) begin
            e = exp_q[d][0];
            chk($sformatf("u%0d_run_rdy", d), 128'(in_ready[d]), 128'(0));
            if (cyc > e.acc + npass(d)) begin
                chk($sformatf("u%0d_late", d), 128'(cyc - e.acc), 128'(npass(d)));
                void'(exp_q[d].pop_front());
            end
        end else begin
            chk($sformatf("u%0d_idle_rdy", d), 128'(in_ready[d]), 128'(1));
        end
        if (in_valid[d] && in_ready[d]) begin
            e.dat = ref_sub(in_data[d]);
            e.acc = cyc + 1;
            exp_q[d].push_back(e);
        end
        prev_ov[d] = out_valid[d];
    endtask

    task automatic monitor();
        while (!done) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) mon_one(d);
        end
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic send(input int d, input logic [127:0] dat);
        logic ok;
        ok = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = dat;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk($sformatf("u%0d_accept_timeout", d), 128'(in_ready[d]), 128'(1));
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (exp_q[d].size() == 0 && !out_valid[d]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk($sformatf("u%0d_drain_timeout", d), 128'(exp_q[d].size()), 128'(0));
    endtask

    task automatic wait_vld(input int d);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid[d]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk($sformatf("u%0d_vld_timeout", d), 128'(out_valid[d]), 128'(1));
    endtask

    task automatic stimulus();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // All-zero state, then the 0..F ramp which maps onto the S-box table itself.
        send(0, 128'h0);
        drain(0);
        send(0, 128'hFEDCBA9876543210_FEDCBA9876543210);
        drain(0);

        // Ten stalled cycles in HOLD with a competing input held on in_valid.
        out_ready[0] = 1'b0;
        send(0, rnd128());
        wait_vld(0);
        in_valid[0] = 1'b1;
        in_data[0]  = rnd128();
        repeat (10) @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        drain(0);

        // Back-to-back stream: each send is taken on the previous result's handshake.
        repeat (4) send(0, rnd128());
        drain(0);

        // Reset while cnt == 2, then confirm silence and a clean restart.
        send(0, rnd128());
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(0, 128'hFFFF_0000_1234_5678_9ABC_DEF0_0F1E_2D3C);
        drain(0);

        repeat (20) send(1, rnd128());
        drain(1);
        repeat (10) send(2, rnd128());
        drain(2);

        for (int d = 0; d < 3; d++)
            chk($sformatf("u%0d_q_empty", d), 128'(exp_q[d].size()), 128'(0));
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d]     = 1'b0;
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b1;
        end
        fork
            monitor();
            begin
                stimulus();
                done = 1'b1;
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
